sram_read_arbiter: RTL and testbench

Shares the single read port of the pattern SRAM between the two string-match engine channels (channel 1, channel 2). It takes per-channel read requests carrying an 8-bit word address, issues at most one SRAM read per cycle under round-robin priority, tracks which channel owns each in-flight read through the fixed SRAM read latency, and returns each 240-bit word to its owner with a one-cycle valid pulse. It sits between the engines and the SRAM, replacing the controller's direct per-channel address drive.

---
 rtl/sram_arb_pkg.sv | 22 ++
 rtl/sram_read_arbiter_if.sv | 27 ++
 rtl/arb_tag_pipe.sv | 32 +++
 rtl/sram_read_arbiter.sv | 102 ++++++++++
 tb/tb_sram_read_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared widths and tag types for the pattern-SRAM read arbiter.
package sram_arb_pkg;

  localparam int SLICE_W = 48;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 5 * SLICE_W;

  typedef enum logic {
    CH1 = 1'b0,
    CH2 = 1'b1
  } chan_id_t;

  typedef struct packed {
    logic     valid;
    chan_id_t id;
  } arb_tag_t;

  function automatic chan_id_t other_chan(chan_id_t c);
    return (c == CH1) ? CH2 : CH1;
  endfunction

endpackage

// File: rtl/sram_read_arbiter_if.sv
// Engine-side request/return signals plus the SRAM read port, seen by the arbiter as slave.
interface sram_read_arbiter_if #(
  parameter int ADDR_W = sram_arb_pkg::ADDR_W,
  parameter int DATA_W = sram_arb_pkg::DATA_W
);
  logic              req1;
  logic              req2;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic              rvalid1;
  logic              rvalid2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  req1, req2, addr1, addr2, sram_rdata,
    output rvalid1, rvalid2, rdata1, rdata2, sram_rd_en, sram_addr
  );

  modport master (
    output req1, req2, addr1, addr2, sram_rdata,
    input  rvalid1, rvalid2, rdata1, rdata2, sram_rd_en, sram_addr
  );
endinterface

// File: rtl/arb_tag_pipe.sv
// Ownership tag delay line; its output lines up with the SRAM data the tagged read returns.
module arb_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clock,
  input  logic     reset,
  input  arb_tag_t i_tag,
  output arb_tag_t o_tag
);

  arb_tag_t r_pipe [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: every stage is reset so reads in flight at reset can never return
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i].valid <= 1'b0;
        r_pipe[i].id    <= CH1;
      end
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter sharing the pattern SRAM read port between two match-engine channels.
module sram_read_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = sram_arb_pkg::ADDR_W,
  parameter int DATA_W       = sram_arb_pkg::DATA_W
) (
  input  logic               clock,
  input  logic               reset,
  sram_read_arbiter_if.slave bus
);
  import sram_arb_pkg::chan_id_t;
  import sram_arb_pkg::arb_tag_t;
  import sram_arb_pkg::CH1;
  import sram_arb_pkg::CH2;
  import sram_arb_pkg::other_chan;

  logic              r_busy1;
  logic              r_busy2;
  chan_id_t          r_prio;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rvalid1;
  logic              r_rvalid2;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;

  logic     w_elig1;
  logic     w_elig2;
  logic     w_grant;
  chan_id_t w_gnt_id;
  arb_tag_t w_push;
  arb_tag_t w_ret;
  logic     w_ret1;
  logic     w_ret2;

  assign w_elig1 = bus.req1 & ~r_busy1;
  assign w_elig2 = bus.req2 & ~r_busy2;
  assign w_grant = w_elig1 | w_elig2;

  always_comb begin
    // NOTE: default assigned first so no path leaves w_gnt_id unassigned (no latch)
    w_gnt_id = CH1;
    if (w_elig1 && w_elig2) begin
      w_gnt_id = r_prio;
    end else if (w_elig2) begin
      w_gnt_id = CH2;
    end
  end

  assign w_push.valid = w_grant;
  assign w_push.id    = w_gnt_id;

  arb_tag_pipe #(
    .DEPTH (READ_LATENCY + 1)
  ) u_tag_pipe (
    .clock (clock),
    .reset (reset),
    .i_tag (w_push),
    .o_tag (w_ret)
  );

  assign w_ret1 = w_ret.valid && (w_ret.id == CH1);
  assign w_ret2 = w_ret.valid && (w_ret.id == CH2);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy1   <= 1'b0;
      r_busy2   <= 1'b0;
      r_prio    <= CH1;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_rvalid1 <= 1'b0;
      r_rvalid2 <= 1'b0;
      r_rdata1  <= '0;
      r_rdata2  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of its peers
      r_rd_en   <= w_grant;
      r_rvalid1 <= w_ret1;
      r_rvalid2 <= w_ret2;
      if (w_grant) begin
        r_addr <= (w_gnt_id == CH2) ? bus.addr2 : bus.addr1;
        r_prio <= other_chan(w_gnt_id);
      end
      if (w_ret1) r_rdata1 <= bus.sram_rdata;
      if (w_ret2) r_rdata2 <= bus.sram_rdata;
      // busy drops on the edge closing the rvalid cycle, so a held request re-arbitrates one cycle later
      if (w_grant && (w_gnt_id == CH1)) r_busy1 <= 1'b1;
      else if (r_rvalid1)               r_busy1 <= 1'b0;
      if (w_grant && (w_gnt_id == CH2)) r_busy2 <= 1'b1;
      else if (r_rvalid2)               r_busy2 <= 1'b0;
    end
  end

  assign bus.sram_rd_en = r_rd_en;
  assign bus.sram_addr  = r_addr;
  assign bus.rvalid1    = r_rvalid1;
  assign bus.rvalid2    = r_rvalid2;
  assign bus.rdata1     = r_rdata1;
  assign bus.rdata2     = r_rdata2;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter: four instances at READ_LATENCY 1..4, lane 0 (latency 1) is the main one.
module tb_sram_read_arbiter;

  localparam int AW = 8;
  localparam int DW = 240;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]         lane_req1;
  logic [3:0]         lane_req2;
  logic [3:0][AW-1:0] lane_addr1;
  logic [3:0][AW-1:0] lane_addr2;
  logic [3:0]         lane_rvalid1;
  logic [3:0]         lane_rvalid2;
  logic [3:0]         lane_rd_en;
  logic [3:0][AW-1:0] lane_sram_addr;
  logic [3:0][DW-1:0] lane_rdata1;
  logic [3:0][DW-1:0] lane_rdata2;

  logic [7:0] junk_byte = 8'h3C;
  always @(posedge clk) junk_byte <= junk_byte + 8'd1;

  function automatic logic [DW-1:0] word_of(logic [AW-1:0] a);
    return {{29{8'hA5}}, a};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_lane
    sram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_read_arbiter #(
      .READ_LATENCY (g + 1),
      .ADDR_W       (AW),
      .DATA_W       (DW)
    ) u_dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
    );

    // SRAM model: data for a strobed address appears g+1 cycles after the strobe
    logic [3:0]    v_q = 4'b0000;
    logic [AW-1:0] a_q [4];
    always @(posedge clk) begin
      v_q    <= {v_q[2:0], bus.sram_rd_en};
      a_q[0] <= bus.sram_addr;
      for (int i = 1; i < 4; i++) a_q[i] <= a_q[i-1];
    end

    assign bus.sram_rdata      = v_q[g] ? word_of(a_q[g]) : {30{junk_byte}};
    assign bus.req1            = lane_req1[g];
    assign bus.req2            = lane_req2[g];
    assign bus.addr1           = lane_addr1[g];
    assign bus.addr2           = lane_addr2[g];
    assign lane_rvalid1[g]     = bus.rvalid1;
    assign lane_rvalid2[g]     = bus.rvalid2;
    assign lane_rd_en[g]       = bus.sram_rd_en;
    assign lane_sram_addr[g]   = bus.sram_addr;
    assign lane_rdata1[g]      = bus.rdata1;
    assign lane_rdata2[g]      = bus.rdata2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lane_req1  = '0;
    lane_req2  = '0;
    lane_addr1 = '0;
    lane_addr2 = '0;
  endtask

  // Leaves the bench at the start of cycle 0: the first edge after this sees reset low
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (lane_rd_en[0] !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b want 0", lane_rd_en[0]); end
    checks++; if (lane_sram_addr[0] !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", lane_sram_addr[0]); end
    checks++; if (lane_rvalid1[0] !== 1'b0) begin errors++; $display("FAIL reset_rvalid1: got %0b want 0", lane_rvalid1[0]); end
    checks++; if (lane_rvalid2[0] !== 1'b0) begin errors++; $display("FAIL reset_rvalid2: got %0b want 0", lane_rvalid2[0]); end
    checks++; if (lane_rdata1[0] !== '0) begin errors++; $display("FAIL reset_rdata1: got %h want 0", lane_rdata1[0]); end
    checks++; if (lane_rdata2[0] !== '0) begin errors++; $display("FAIL reset_rdata2: got %h want 0", lane_rdata2[0]); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    lane_req1[0]  = 1'b1;
    lane_addr1[0] = 8'h10;
    tick();  // cycle 1
    checks++; if (lane_rd_en[0] !== 1'b1) begin errors++; $display("FAIL single_rd_en: got %0b want 1", lane_rd_en[0]); end
    checks++; if (lane_sram_addr[0] !== 8'h10) begin errors++; $display("FAIL single_addr: got %h want 10", lane_sram_addr[0]); end
    tick();  // cycle 2
    checks++; if (lane_rvalid1[0] !== 1'b0) begin errors++; $display("FAIL single_early_rvalid1: got %0b want 0", lane_rvalid1[0]); end
    tick();  // cycle 3
    checks++; if (lane_rvalid1[0] !== 1'b1) begin errors++; $display("FAIL single_rvalid1: got %0b want 1", lane_rvalid1[0]); end
    checks++; if (lane_rdata1[0] !== word_of(8'h10)) begin errors++; $display("FAIL single_rdata1: got %h want %h", lane_rdata1[0], word_of(8'h10)); end
    checks++; if (lane_rvalid2[0] !== 1'b0) begin errors++; $display("FAIL single_rvalid2: got %0b want 0", lane_rvalid2[0]); end
    lane_req1[0] = 1'b0;
    tick();  // cycle 4
    checks++; if (lane_rvalid1[0] !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %0b want 0", lane_rvalid1[0]); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    lane_req1[0] = 1'b1; lane_addr1[0] = 8'h01;
    lane_req2[0] = 1'b1; lane_addr2[0] = 8'h02;
    tick();  // cycle 1
    checks++; if (lane_rd_en[0] !== 1'b1 || lane_sram_addr[0] !== 8'h01) begin errors++; $display("FAIL sim_issue1: got en=%0b addr=%h want en=1 addr=01", lane_rd_en[0], lane_sram_addr[0]); end
    tick();  // cycle 2
    checks++; if (lane_rd_en[0] !== 1'b1 || lane_sram_addr[0] !== 8'h02) begin errors++; $display("FAIL sim_issue2: got en=%0b addr=%h want en=1 addr=02", lane_rd_en[0], lane_sram_addr[0]); end
    tick();  // cycle 3
    checks++; if (lane_rvalid1[0] !== 1'b1 || lane_rvalid2[0] !== 1'b0) begin errors++; $display("FAIL sim_rvalid_c3: got rv1=%0b rv2=%0b want rv1=1 rv2=0", lane_rvalid1[0], lane_rvalid2[0]); end
    checks++; if (lane_rdata1[0] !== word_of(8'h01)) begin errors++; $display("FAIL sim_rdata1: got %h want %h", lane_rdata1[0], word_of(8'h01)); end
    lane_req1[0] = 1'b0;
    tick();  // cycle 4
    checks++; if (lane_rvalid2[0] !== 1'b1 || lane_rvalid1[0] !== 1'b0) begin errors++; $display("FAIL sim_rvalid_c4: got rv1=%0b rv2=%0b want rv1=0 rv2=1", lane_rvalid1[0], lane_rvalid2[0]); end
    checks++; if (lane_rdata2[0] !== word_of(8'h02)) begin errors++; $display("FAIL sim_rdata2: got %h want %h", lane_rdata2[0], word_of(8'h02)); end
    lane_req2[0] = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] want_addr;
    int issues;
    int n1;
    int n2;
    do_reset();
    lane_req1[0] = 1'b1; lane_addr1[0] = 8'h21;
    lane_req2[0] = 1'b1; lane_addr2[0] = 8'h42;
    want_addr = 8'h21;
    issues = 0; n1 = 0; n2 = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (lane_rd_en[0]) begin
        checks++;
        if (lane_sram_addr[0] !== want_addr) begin errors++; $display("FAIL rr_order cycle %0d: got addr %h want %h", c, lane_sram_addr[0], want_addr); end
        want_addr = (want_addr == 8'h21) ? 8'h42 : 8'h21;
        issues++;
      end
      if (lane_rvalid1[0]) n1++;
      if (lane_rvalid2[0]) n2++;
      checks++;
      if (lane_rvalid1[0] && lane_rvalid2[0]) begin errors++; $display("FAIL rr_dual_rvalid cycle %0d: got both high want at most one", c); end
      if (c == 40) begin lane_req1[0] = 1'b0; lane_req2[0] = 1'b0; end
    end
    checks++; if (issues != 20) begin errors++; $display("FAIL rr_issue_count: got %0d want 20", issues); end
    checks++; if (n1 != 10 || n2 != 10) begin errors++; $display("FAIL rr_rvalid_counts: got %0d/%0d want 10/10", n1, n2); end
    repeat (4) tick();
  endtask

  task automatic test_latency_sweep();
    int first_cyc [4];
    logic [DW-1:0] got [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lane_req1[i]  = 1'b1;
      lane_addr1[i] = 8'h10;
      first_cyc[i]  = -1;
      got[i]        = '0;
    end
    for (int c = 1; c <= 10; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (lane_rvalid1[i] && first_cyc[i] < 0) begin
          first_cyc[i] = c;
          got[i]       = lane_rdata1[i];
          lane_req1[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (first_cyc[i] != 3 + i) begin errors++; $display("FAIL sweep_lat%0d_cycle: got %0d want %0d", i + 1, first_cyc[i], 3 + i); end
      checks++; if (got[i] !== word_of(8'h10)) begin errors++; $display("FAIL sweep_lat%0d_rdata: got %h want %h", i + 1, got[i], word_of(8'h10)); end
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_reset_midflight();
    int seen;
    do_reset();
    lane_req2[0] = 1'b1; lane_addr2[0] = 8'h33;
    tick();  // cycle 1: strobe for channel 2 on the bus
    checks++; if (lane_rd_en[0] !== 1'b1 || lane_sram_addr[0] !== 8'h33) begin errors++; $display("FAIL mid_issue: got en=%0b addr=%h want en=1 addr=33", lane_rd_en[0], lane_sram_addr[0]); end
    rst = 1'b1;
    lane_req2[0] = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if (lane_rd_en[0] !== 1'b0 || lane_sram_addr[0] !== 8'h00) begin errors++; $display("FAIL mid_reset_strobe: got en=%0b addr=%h want en=0 addr=00", lane_rd_en[0], lane_sram_addr[0]); end
    checks++; if (lane_rvalid1[0] !== 1'b0 || lane_rvalid2[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_rvalid: got rv1=%0b rv2=%0b want 0/0", lane_rvalid1[0], lane_rvalid2[0]); end
    checks++; if (lane_rdata1[0] !== '0 || lane_rdata2[0] !== '0) begin errors++; $display("FAIL mid_reset_rdata: got %h / %h want 0", lane_rdata1[0], lane_rdata2[0]); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (lane_rvalid1[0] || lane_rvalid2[0]) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_stale_rvalid: got %0d pulses want 0", seen); end
    lane_req1[0] = 1'b1; lane_addr1[0] = 8'h44;
    lane_req2[0] = 1'b1; lane_addr2[0] = 8'h55;
    tick();
    checks++; if (lane_rd_en[0] !== 1'b1 || lane_sram_addr[0] !== 8'h44) begin errors++; $display("FAIL mid_first_grant: got en=%0b addr=%h want en=1 addr=44", lane_rd_en[0], lane_sram_addr[0]); end
    tick();
    checks++; if (lane_sram_addr[0] !== 8'h55) begin errors++; $display("FAIL mid_second_grant: got addr=%h want 55", lane_sram_addr[0]); end
    tick();
    lane_req1[0] = 1'b0;
    tick();
    lane_req2[0] = 1'b0;
    tick();
  endtask

  task automatic test_data_hold();
    logic found;
    do_reset();
    lane_req2[0] = 1'b1; lane_addr2[0] = 8'h66;
    found = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (!found && lane_rvalid2[0]) begin
        found = 1'b1;
        lane_req2[0] = 1'b0;
      end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL hold_rvalid2: got no pulse within 8 cycles want pulse"); end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (lane_rdata2[0] !== word_of(8'h66)) begin errors++; $display("FAIL hold_rdata2 cycle %0d: got %h want %h", c, lane_rdata2[0], word_of(8'h66)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_latency_sweep();
    test_reset_midflight();
    test_data_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
